// File: rtl/fir_stream_if.sv
`default_nettype none
// ============================================================================
// fir_stream_if : sample/result handshake and coefficient-write bundle.
// Rev 1.0
// ============================================================================
interface fir_stream_if #(
   parameter int DATA_W = 8,
   parameter int COEF_W = 8,
   parameter int TAPS   = 4,
   parameter int OUT_W  = 10
);
   localparam int c_AW = $clog2(TAPS);

   logic [DATA_W-1:0] in0;
   logic              in_valid;
   logic              in_ready;
   logic [OUT_W-1:0]  out0;
   logic              out_valid;
   logic              out_ready;
   logic              sat;
   logic              coef_we;
   logic [c_AW-1:0]   coef_addr;
   logic [COEF_W-1:0] coef_data;

   modport master (
      output in0, in_valid, out_ready, coef_we, coef_addr, coef_data,
      input  in_ready, out0, out_valid, sat
   );

   modport slave (
      input  in0, in_valid, out_ready, coef_we, coef_addr, coef_data,
      output in_ready, out0, out_valid, sat
   );
endinterface
`default_nettype wire

// File: rtl/fir_stream.sv
`default_nettype none
// ============================================================================
// fir_stream : streaming direct-form FIR, loadable coefficients, valid/ready,
// scaled + saturated output. Round-half-up enabled by FIR_STREAM_ROUND_EN.
// Rev 1.0
// ============================================================================
module fir_stream #(
   parameter int DATA_W = 8,
   parameter int COEF_W = 8,
   parameter int TAPS   = 4,
   parameter int OUT_W  = 10,
   parameter int SHIFT  = 0
) (
   input  wire logic   clk,
   input  wire logic   rst,
   fir_stream_if.slave s
);
   localparam int c_AW    = $clog2(TAPS);
   localparam int c_ACC_W = DATA_W + COEF_W + $clog2(TAPS);
   localparam int c_CW    = (OUT_W > c_ACC_W + 1) ? OUT_W : c_ACC_W + 1;
   localparam logic [c_AW:0]   c_TAPS = (c_AW + 1)'(TAPS);
   localparam logic [c_CW-1:0] c_MAX  = c_CW'({OUT_W{1'b1}});

   logic [DATA_W-1:0]  r_dly  [TAPS-1];
   logic [COEF_W-1:0]  r_coef [TAPS];
   logic [OUT_W-1:0]   r_out0;
   logic               r_out_valid;
   logic               r_sat;

   logic [DATA_W-1:0]  w_x    [TAPS];
   logic [c_ACC_W-1:0] w_prod [TAPS];
   logic [c_ACC_W-1:0] w_acc;
   logic [c_ACC_W:0]   w_sum;
   logic [c_ACC_W:0]   w_scaled;
   logic [c_CW-1:0]    w_ext;
   logic               w_sat;
   logic [OUT_W-1:0]   w_out;
   logic               w_in_ready;
   logic               w_accept;
   logic               w_coef_ok;

   // Tap 0 sees the incoming sample; later taps see the pre-shift delay line.
   for (genvar k = 0; k < TAPS; k++) begin : g_tap
      if (k == 0) begin : g_in
         assign w_x[k] = s.in0;
      end else begin : g_dly
         assign w_x[k] = r_dly[k-1];
      end
      assign w_prod[k] = c_ACC_W'(w_x[k]) * c_ACC_W'(r_coef[k]);
   end

   always_comb begin
      w_acc = '0;
      for (int k = 0; k < TAPS; k++) begin
         w_acc = w_acc + w_prod[k];
      end
   end

`ifdef FIR_STREAM_ROUND_EN
   localparam logic [c_ACC_W:0] c_RND =
      (SHIFT > 0) ? ((c_ACC_W + 1)'(1) << ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;
   assign w_sum = {1'b0, w_acc} + c_RND;
`else
   assign w_sum = {1'b0, w_acc};
`endif

   assign w_scaled   = w_sum >> SHIFT;
   assign w_ext      = c_CW'(w_scaled);
   assign w_sat      = (w_ext > c_MAX);
   assign w_out      = w_sat ? {OUT_W{1'b1}} : w_ext[OUT_W-1:0];

   assign w_in_ready = !r_out_valid || s.out_ready;
   assign w_accept   = s.in_valid && w_in_ready;
   assign w_coef_ok  = ({1'b0, s.coef_addr} < c_TAPS);

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < TAPS - 1; k++) r_dly[k] <= '0;
         for (int k = 0; k < TAPS; k++)     r_coef[k] <= COEF_W'(1);
         r_out0      <= '0;
         r_out_valid <= 1'b0;
         r_sat       <= 1'b0;
      end else begin
         if (w_accept) begin
            r_dly[0] <= s.in0;
            for (int k = 1; k < TAPS - 1; k++) r_dly[k] <= r_dly[k-1];
            r_out0      <= w_out;
            r_sat       <= w_sat;
            r_out_valid <= 1'b1;
         end else if (s.out_ready) begin
            r_out_valid <= 1'b0;
         end
         // Write lands after this edge, so a coincident accept uses the old value.
         if (s.coef_we && w_coef_ok) begin
            r_coef[s.coef_addr] <= s.coef_data;
         end
      end
   end

   assign s.in_ready  = w_in_ready;
   assign s.out0      = r_out0;
   assign s.out_valid = r_out_valid;
   assign s.sat       = r_sat;
endmodule
`default_nettype wire

// File: tb/tb_fir_stream.sv
`default_nettype none
// ============================================================================
// tb_fir_stream : directed self-checking bench for fir_stream.
// Rev 1.0
// ============================================================================
module tb_fir_stream;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_pass = 0;
   int   n_chk  = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   fir_stream_if #(.DATA_W(8), .COEF_W(8), .TAPS(4), .OUT_W(10)) ifa ();
   fir_stream_if #(.DATA_W(8), .COEF_W(8), .TAPS(4), .OUT_W(10)) ifb ();

   fir_stream #(.DATA_W(8), .COEF_W(8), .TAPS(4), .OUT_W(10), .SHIFT(0)) u_dut_a (
      .clk (clk),
      .rst (rst),
      .s   (ifa)
   );

   fir_stream #(.DATA_W(8), .COEF_W(8), .TAPS(4), .OUT_W(10), .SHIFT(2)) u_dut_b (
      .clk (clk),
      .rst (rst),
      .s   (ifb)
   );

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   int t1_in  [5] = '{10, 0, 0, 0, 0};
   int t1_exp [5] = '{10, 10, 10, 10, 0};
   int t2_exp [5] = '{1, 2, 3, 4, 0};
`ifdef FIR_STREAM_ROUND_EN
   int t6_exp [4] = '{0, 1, 1, 1};
`else
   int t6_exp [4] = '{0, 0, 0, 1};
`endif

   initial begin
      ifa.in0 = '0; ifa.in_valid = 0; ifa.out_ready = 1;
      ifa.coef_we = 0; ifa.coef_addr = '0; ifa.coef_data = '0;
      ifb.in0 = '0; ifb.in_valid = 0; ifb.out_ready = 1;
      ifb.coef_we = 0; ifb.coef_addr = '0; ifb.coef_data = '0;
      cyc(); cyc();
      chk("rst_valid", 32'(ifa.out_valid), 0);
      chk("rst_out0",  32'(ifa.out0), 0);
      chk("rst_sat",   32'(ifa.sat), 0);
      chk("rst_ready", 32'(ifa.in_ready), 1);
      rst = 0;

      // Moving sum with reset coefficients.
      for (int i = 0; i < 5; i++) begin
         ifa.in_valid = 1; ifa.in0 = 8'(t1_in[i]);
         cyc();
         chk("sum_out0",  32'(ifa.out0), 32'(t1_exp[i]));
         chk("sum_valid", 32'(ifa.out_valid), 1);
         chk("sum_sat",   32'(ifa.sat), 0);
      end
      ifa.in_valid = 0;
      cyc();
      chk("drain_valid", 32'(ifa.out_valid), 0);

      // Load c = {1,2,3,4}.
      for (int k = 0; k < 4; k++) begin
         ifa.coef_we = 1; ifa.coef_addr = 2'(k); ifa.coef_data = 8'(k + 1);
         cyc();
      end
      ifa.coef_we = 0;

      // Impulse; writes to c0 and c3 coincide with accepts and must not apply yet.
      for (int i = 0; i < 5; i++) begin
         ifa.in_valid = 1; ifa.in0 = (i == 0) ? 8'd1 : 8'd0;
         ifa.coef_we = (i == 0 || i == 3);
         ifa.coef_addr = (i == 0) ? 2'd0 : 2'd3;
         ifa.coef_data = (i == 0) ? 8'd7 : 8'd9;
         cyc();
         chk("imp_out0", 32'(ifa.out0), 32'(t2_exp[i]));
      end
      ifa.coef_we = 0;
      ifa.in0 = 8'd1; cyc();
      chk("newc0_out0", 32'(ifa.out0), 7);
      ifa.in0 = 8'd0; cyc();
      chk("c1_out0", 32'(ifa.out0), 2);
      ifa.in_valid = 0;

      // Saturation with all coefficients 255 from clean history.
      rst = 1; cyc(); rst = 0;
      for (int k = 0; k < 4; k++) begin
         ifa.coef_we = 1; ifa.coef_addr = 2'(k); ifa.coef_data = 8'd255;
         cyc();
      end
      ifa.coef_we = 0;
      for (int i = 0; i < 4; i++) begin
         ifa.in_valid = 1; ifa.in0 = 8'd255;
         cyc();
         chk("sat_out0", 32'(ifa.out0), 1023);
         chk("sat_flag", 32'(ifa.sat), 1);
      end
      ifa.in_valid = 0;

      // Reset restores unit coefficients; then back-pressure.
      rst = 1; cyc(); rst = 0;
      chk("rst2_valid", 32'(ifa.out_valid), 0);
      ifa.in_valid = 1; ifa.in0 = 8'd5;
      cyc();
      chk("bp_first", 32'(ifa.out0), 5);
      chk("bp_first_sat", 32'(ifa.sat), 0);
      ifa.out_ready = 0; ifa.in0 = 8'd7;
      for (int i = 0; i < 5; i++) begin
         cyc();
         chk("bp_ready", 32'(ifa.in_ready), 0);
         chk("bp_hold",  32'(ifa.out0), 5);
         chk("bp_valid", 32'(ifa.out_valid), 1);
      end
      ifa.out_ready = 1;
      cyc();
      chk("bp_release", 32'(ifa.out0), 12);
      chk("bp_rel_valid", 32'(ifa.out_valid), 1);
      ifa.in0 = 8'd1;
      cyc();
      chk("bp_next", 32'(ifa.out0), 13);
      ifa.in_valid = 0;
      cyc();
      chk("bp_drain", 32'(ifa.out_valid), 0);

      // Ramp with reset between samples 2 and 3; history is d = {1,7,5}.
      ifa.in_valid = 1; ifa.in0 = 8'd1; cyc();
      chk("ramp1", 32'(ifa.out0), 14);
      ifa.in0 = 8'd2; cyc();
      chk("ramp2", 32'(ifa.out0), 11);
      ifa.in_valid = 0; rst = 1; cyc(); rst = 0;
      chk("mid_rst_valid", 32'(ifa.out_valid), 0);
      chk("mid_rst_out0",  32'(ifa.out0), 0);
      ifa.in_valid = 1; ifa.in0 = 8'd4; cyc();
      chk("ramp4", 32'(ifa.out0), 4);
      ifa.in0 = 8'd5; cyc();
      chk("ramp5", 32'(ifa.out0), 9);
      ifa.in_valid = 0;

      // SHIFT=2 instance: truncation vs round-half-up.
      for (int i = 0; i < 4; i++) begin
         ifb.in_valid = 1; ifb.in0 = 8'd1;
         cyc();
         chk("shift_out0", 32'(ifb.out0), 32'(t6_exp[i]));
      end
      ifb.in_valid = 0;
      cyc();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/fir_stream.md
Name: fir_stream

Overview:
- Parametrised, streaming direct-form FIR filter: next generation of the team's fixed 8-bit-in / 10-bit-out FIR.
- Adds generic tap count and widths, runtime-loadable coefficients, valid/ready handshake with back-pressure, output scaling with saturation, and optional rounding.
- Sits between a sample source (dataset reader / upstream block) and the approximation-error measurement sink.

Parameters:
- DATA_W, 8: input sample width, unsigned.
- COEF_W, 8: coefficient width, unsigned.
- TAPS, 4: number of taps, >= 2.
- OUT_W, 10: output width, unsigned.
- SHIFT, 0: right shift applied to the accumulator before saturation, 0..(ACC_W-1).

Ports:
- clk, in, 1: clock, rising edge.
- rst, in, 1: synchronous active-high reset.
- in0, in, DATA_W: input sample.
- in_valid, in, 1: in0 valid.
- in_ready, out, 1: block can accept a sample.
- out0, out, OUT_W: filtered output.
- out_valid, out, 1: out0 valid.
- out_ready, in, 1: downstream accepts out0.
- sat, out, 1: out0 of the current result was saturated (qualified by out_valid).
- coef_we, in, 1: coefficient write strobe.
- coef_addr, in, $clog2(TAPS): tap index to write.
- coef_data, in, COEF_W: coefficient value.

Behaviour:
- Clock and reset: single clock clk; rst is synchronous, active-high, sampled on the rising edge.
- Reset:
  - Delay line all 0; coefficients all 1 (moving sum).
  - out0=0, out_valid=0, sat=0.
  - in_ready is combinational and therefore 1 out of reset.
- in_ready = !out_valid || out_ready. Accept happens when in_valid && in_ready at a rising edge.
- On accept:
  - Delay line shifts: d[0]<=in0, d[k]<=d[k-1].
  - acc = sum over k of c[k]*x[k], where x[0]=in0 and x[k]=d[k-1] (pre-shift values).
  - out0/sat are registered at the same edge; out_valid<=1. Latency 1 cycle, throughput 1 sample/cycle.
- Width rules:
  - ACC_W = DATA_W+COEF_W+$clog2(TAPS), full precision, no internal overflow.
  - scaled = acc >> SHIFT.
  - If scaled > 2^OUT_W-1: out0 = 2^OUT_W-1 and sat=1; else out0=scaled and sat=0.
- Output handshake:
  - out_valid && out_ready with no new accept: out_valid<=0.
  - Simultaneous drain and accept: out_valid stays 1 and out0 takes the new value.
  - out_valid && !out_ready: out0/sat held stable, in_ready=0, delay line frozen.
- No accept: delay line unchanged; in_valid with in_ready=0 has no effect.
- Coefficient write:
  - c[coef_addr]<=coef_data on coef_we.
  - coef_addr >= TAPS is ignored.
  - Write in the same cycle as an accept: that accept uses the old coefficient; the new value applies from the next accept.
  - Writes are allowed while stalled.
- Reset mid-operation: in-flight output discarded, delay line cleared, coefficients return to 1; the first accept after reset sees zero history.
- Default parameters: coefficients all 1 give a 4-sample sum; max 4*255=1020, never saturates.

Optional Feature:
- Macro FIR_STREAM_ROUND_EN.
- Defined: scaled = (acc + (SHIFT>0 ? 2^(SHIFT-1) : 0)) >> SHIFT (round half up), computed in ACC_W+1 bits before saturation.
- Not defined: truncation (plain >> SHIFT).
- SHIFT=0: identical behaviour either way.

Test Plan:
- Default params, out_ready=1, coefficients at reset: in0 = 10,0,0,0,0 -> out0 = 10,10,10,10,0 one cycle after each accept; sat=0.
- Write c = {1,2,3,4}, then impulse 1 followed by zeros -> out0 = 1,2,3,4,0. Repeat with a write to coef_addr=3 coinciding with the first accept: that accept uses the old c[3].
- All coefficients 255, in0=255 x4 -> acc = 260100 -> out0 = 1023, sat=1 once the sum exceeds 1023 (first output 65025 -> 1023, sat=1).
- Back-pressure: out_ready=0 after the first result, in_valid held high -> in_ready=0, out0 stable for 5 cycles, delay line unchanged. Release out_ready -> drain and accept in the same cycle, next sample continues the sequence correctly.
- SHIFT=2, coefficients 1, in0=1,1 -> second out0 = 0 (truncate) / 1 (FIR_STREAM_ROUND_EN).
- Assert rst for 1 cycle between samples 2 and 3 of a ramp 1..5 -> out_valid=0, out0=0 next cycle; the next accept of 4 gives out0=4.
